// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812B single-wire NRZ stream decoder.
// Measures each high pulse on the synchronised data line and decodes it as a 0 or 1 bit.
// Assembles 24-bit GRB words and presents them as {R,G,B} with a per-frame pixel index.
// The latch gap (a long low period) marks the end of a frame.
module ws2812_rx #(
    parameter int BIT_THRESH   = 10,
    parameter int MIN_HIGH     = 3,
    parameter int MAX_HIGH     = 30,
    parameter int RESET_CYCLES = 800
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        din,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic        error,
    output logic        overflow
);

    localparam int HW = $clog2(MAX_HIGH + 2);
    localparam int LW = $clog2(RESET_CYCLES + 1);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    state_t        state_r;
    logic          sync_r;
    logic          din_s;
    logic          din_prev_r;
    logic          rise_s;
    logic [HW-1:0] hi_cnt_r;
    logic [LW-1:0] low_cnt_r;
    logic [23:0]   shift_r;
    logic [4:0]    bit_cnt_r;
    logic [8:0]    pix_cnt_r;
    logic          pix_pend_r;
    logic          got_bit_r;

    assign rise_s = din_s & ~din_prev_r;

    // Two-flop synchroniser for the asynchronous data line plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_r     <= 1'b0;
            din_s      <= 1'b0;
            din_prev_r <= 1'b0;
        end else begin
            sync_r     <= din;
            din_s      <= sync_r;
            din_prev_r <= din_s;
        end
    end

    // Decoder FSM: pulse measurement, bit assembly, pixel output and latch-gap detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= SYNC;
            hi_cnt_r    <= '0;
            low_cnt_r   <= '0;
            shift_r     <= 24'd0;
            bit_cnt_r   <= 5'd0;
            pix_cnt_r   <= 9'd0;
            pix_pend_r  <= 1'b0;
            got_bit_r   <= 1'b0;
            rgb_data    <= 24'd0;
            led_num     <= 8'd0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            error       <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            error       <= 1'b0;

            // A full word was shifted in last cycle: present it (wire order G,R,B -> R,G,B).
            // The index saturates at 256 internally so the 257th and later pixels report 255.
            if (pix_pend_r) begin
                pix_pend_r  <= 1'b0;
                pixel_valid <= 1'b1;
                rgb_data    <= {shift_r[15:8], shift_r[23:16], shift_r[7:0]};
                bit_cnt_r   <= 5'd0;
                if (pix_cnt_r[8]) begin
                    led_num  <= 8'd255;
                    overflow <= 1'b1;
                end else begin
                    led_num   <= pix_cnt_r[7:0];
                    pix_cnt_r <= pix_cnt_r + 9'd1;
                end
            end

            case (state_r)
                SYNC: begin
                    if (din_s) begin
                        low_cnt_r <= '0;
                    end else if (low_cnt_r >= LW'(RESET_CYCLES - 1)) begin
                        // Line has been quiet long enough: a fresh frame starts here.
                        low_cnt_r <= '0;
                        pix_cnt_r <= 9'd0;
                        overflow  <= 1'b0;
                        got_bit_r <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        low_cnt_r <= low_cnt_r + LW'(1);
                    end
                end
                IDLE: begin
                    if (rise_s) begin
                        hi_cnt_r <= HW'(1);
                        state_r  <= HIGH;
                    end else begin
                        hi_cnt_r <= '0;
                    end
                end
                HIGH: begin
                    if (din_s) begin
                        if (hi_cnt_r >= HW'(MAX_HIGH)) begin
                            // Stuck-high line: drop the partial pixel and resynchronise.
                            error     <= 1'b1;
                            bit_cnt_r <= 5'd0;
                            hi_cnt_r  <= '0;
                            low_cnt_r <= '0;
                            state_r   <= SYNC;
                        end else begin
                            hi_cnt_r <= hi_cnt_r + HW'(1);
                        end
                    end else if (hi_cnt_r < HW'(MIN_HIGH)) begin
                        // Glitch: too short to be a real bit.
                        error     <= 1'b1;
                        bit_cnt_r <= 5'd0;
                        hi_cnt_r  <= '0;
                        low_cnt_r <= '0;
                        state_r   <= SYNC;
                    end else begin
                        shift_r   <= {shift_r[22:0], (hi_cnt_r >= HW'(BIT_THRESH))};
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                        if (bit_cnt_r == 5'd23) begin
                            pix_pend_r <= 1'b1;
                        end else begin
                            pix_pend_r <= 1'b0;
                        end
                        got_bit_r <= 1'b1;
                        low_cnt_r <= LW'(1);
                        state_r   <= LOW;
                    end
                end
                LOW: begin
                    if (rise_s) begin
                        hi_cnt_r <= HW'(1);
                        state_r  <= HIGH;
                    end else if (low_cnt_r >= LW'(RESET_CYCLES - 1)) begin
                        // Latch gap: close the frame; leftover bits mean a truncated pixel.
                        frame_done <= got_bit_r;
                        error      <= (bit_cnt_r != 5'd0);
                        bit_cnt_r  <= 5'd0;
                        pix_cnt_r  <= 9'd0;
                        overflow   <= 1'b0;
                        got_bit_r  <= 1'b0;
                        low_cnt_r  <= '0;
                        state_r    <= IDLE;
                    end else begin
                        low_cnt_r <= low_cnt_r + LW'(1);
                    end
                end
                default: begin
                    state_r <= SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: table-driven single-pixel frames plus hand-written corner sequences,
// with a scoreboard queue of expected pixels popped on every pixel_valid strobe.
module tb_ws2812_rx;

    logic        clk;
    logic        reset_n;
    logic        din;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        pixel_valid;
    logic        frame_done;
    logic        error;
    logic        overflow;

    ws2812_rx dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .din         (din),
        .rgb_data    (rgb_data),
        .led_num     (led_num),
        .pixel_valid (pixel_valid),
        .frame_done  (frame_done),
        .error       (error),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] word;
        int          t1;
        int          t0;
        logic [23:0] exp_rgb;
    } vec_t;

    typedef struct {
        logic [23:0] rgb;
        logic [7:0]  idx;
        logic        ovf;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int pix_in_frame = 0;
    int n_pv = 0;
    int n_fd = 0;
    int n_err = 0;
    int n_fd_err = 0;
    int s_pv, s_fd, s_err, s_fde;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: counts strobes and checks each emitted pixel against the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (pixel_valid) begin
                n_pv++;
                if (sb.size() == 0) begin
                    chk("unexpected_pixel", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rgb_data", {8'd0, rgb_data}, {8'd0, e.rgb});
                    chk("led_num", {24'd0, led_num}, {24'd0, e.idx});
                    chk("overflow_at_pixel", {31'd0, overflow}, {31'd0, e.ovf});
                    chk("latency", cyc - fall_cyc, 32'd4);
                end
            end
            if (frame_done) n_fd++;
            if (error) n_err++;
            if (frame_done && error) n_fd_err++;
            if (pixel_valid && frame_done) chk("pv_fd_exclusive", 32'd1, 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input int th, input int tl);
        din = 1'b1;
        tick(th);
        din = 1'b0;
        fall_cyc = cyc;
        tick(tl);
    endtask

    task automatic send_bits(input logic [23:0] word, input int nbits, input int t1, input int t0, input int lowt);
        for (int i = 23; i > 23 - nbits; i--) begin
            int th;
            int tl;
            th = word[i] ? t1 : t0;
            tl = (lowt > 0) ? lowt : ((20 - th) < 5 ? 5 : 20 - th);
            send_bit(th, tl);
        end
    endtask

    task automatic send_pixel(input logic [23:0] word, input int t1, input int t0, input int lowt,
                              input logic [23:0] exp_rgb, input bit push);
        if (push) begin
            exp_t e;
            e.rgb = exp_rgb;
            e.idx = (pix_in_frame > 255) ? 8'd255 : 8'(pix_in_frame);
            e.ovf = (pix_in_frame >= 256);
            sb.push_back(e);
            pix_in_frame++;
        end
        send_bits(word, 24, t1, t0, lowt);
    endtask

    task automatic gap(input int n);
        din = 1'b0;
        tick(n);
        pix_in_frame = 0;
    endtask

    task automatic snap();
        s_pv = n_pv;
        s_fd = n_fd;
        s_err = n_err;
        s_fde = n_fd_err;
    endtask

    task automatic expect_counts(input string tag, input int dpv, input int dfd, input int derr);
        chk({tag, "_pv_count"}, n_pv - s_pv, dpv);
        chk({tag, "_fd_count"}, n_fd - s_fd, dfd);
        chk({tag, "_err_count"}, n_err - s_err, derr);
        chk({tag, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rgb"}, {8'd0, rgb_data}, 32'd0);
        chk({tag, "_led_num"}, {24'd0, led_num}, 32'd0);
        chk({tag, "_strobes"}, {29'd0, pixel_valid, frame_done, error}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{word: 24'h007F00, t1: 13, t0: 6, exp_rgb: 24'h7F0000};
        vecs[1] = '{word: 24'hA53C0F, t1: 13, t0: 6, exp_rgb: 24'h3CA50F};
        vecs[2] = '{word: 24'hFFFFFF, t1: 9,  t0: 6, exp_rgb: 24'h000000};
        vecs[3] = '{word: 24'hFFFFFF, t1: 10, t0: 6, exp_rgb: 24'hFFFFFF};
        vecs[4] = '{word: 24'h000000, t1: 13, t0: 3, exp_rgb: 24'h000000};
        vecs[5] = '{word: 24'hFFFFFF, t1: 30, t0: 6, exp_rgb: 24'hFFFFFF};

        reset_n = 1'b0;
        din = 1'b0;
        tick(4);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        gap(810);

        // Table: single-pixel frames covering nominal coding and pulse-width boundaries.
        for (int v = 0; v < 6; v++) begin
            snap();
            send_pixel(vecs[v].word, vecs[v].t1, vecs[v].t0, 0, vecs[v].exp_rgb, 1'b1);
            gap(810);
            expect_counts($sformatf("vec%0d", v), 1, 1, 0);
        end

        // Multi-pixel frame, then a new frame must restart the index at 0.
        snap();
        for (int p = 0; p < 8; p++) begin
            if (p % 2 == 0) send_pixel(24'h007F00, 13, 6, 0, 24'h7F0000, 1'b1);
            else            send_pixel(24'h7F0000, 13, 6, 0, 24'h007F00, 1'b1);
        end
        gap(810);
        expect_counts("multi", 8, 1, 0);
        snap();
        send_pixel(24'h0000AA, 13, 6, 0, 24'h0000AA, 1'b1);
        gap(810);
        expect_counts("restart", 1, 1, 0);

        // Glitch mid-pixel: pixel sent before the line has been quiet for a full gap is ignored.
        snap();
        send_bits(24'hFFFFFF, 5, 13, 6, 0);
        send_bit(2, 18);
        gap(400);
        send_pixel(24'h123456, 13, 6, 0, 24'h0, 1'b0);
        gap(810);
        send_pixel(24'h123456, 13, 6, 0, 24'h341256, 1'b1);
        gap(810);
        expect_counts("glitch", 1, 1, 1);

        // Stuck-high line.
        snap();
        send_bits(24'hFFFFFF, 3, 13, 6, 0);
        send_bit(40, 10);
        gap(810);
        send_pixel(24'h00FF00, 13, 6, 0, 24'hFF0000, 1'b1);
        gap(810);
        expect_counts("stuck", 1, 1, 1);

        // Partial frame: frame_done and error in the same cycle.
        snap();
        send_bits(24'hFFF000, 12, 13, 6, 0);
        gap(810);
        expect_counts("partial", 0, 1, 1);
        chk("partial_fd_err_same_cycle", n_fd_err - s_fde, 32'd1);

        // Reset mid-pixel: outputs clear, following bits ignored until a full gap.
        snap();
        send_bits(24'hFFFFFF, 10, 13, 6, 0);
        reset_n = 1'b0;
        tick(1);
        check_outputs_zero("midreset");
        reset_n = 1'b1;
        send_bits(24'hFFFFFF, 14, 13, 6, 0);
        gap(810);
        send_pixel(24'h80FF01, 13, 6, 0, 24'hFF8001, 1'b1);
        gap(810);
        expect_counts("midreset", 1, 1, 0);

        // Overflow: 257 pixels in one frame.
        snap();
        for (int p = 0; p < 257; p++) begin
            send_pixel(24'h000000, 13, 3, 5, 24'h000000, 1'b1);
        end
        tick(3);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_led_num", {24'd0, led_num}, 32'd255);
        gap(810);
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        expect_counts("ovf", 257, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
Single-wire WS2812B stream decoder: the receiving end of the NRZ pixel protocol our ws2812 transmitter drives.
- Samples a data line at 16 MHz and classifies each high pulse as a 0 or 1 bit.
- Assembles 24-bit GRB words and emits them as {R,G,B} with a per-frame pixel index.
- Signals end-of-frame on the latch/reset gap.
- Used for loopback self-test of the LED driver and for chaining to downstream boards.

Parameters:
BIT_THRESH, 10, high-time in clk cycles at or above which a pulse decodes as 1 (below decodes as 0)
MIN_HIGH, 3, high pulses shorter than this are glitches (error)
MAX_HIGH, 30, high pulses longer than this are stuck-line errors
RESET_CYCLES, 800, continuous low cycles that constitute the latch gap (50 us at 16 MHz)

Ports:
clk  input  1  system clock, 16 MHz
reset_n  input  1  synchronous, active-low reset
din  input  1  WS2812B serial data line, asynchronous to clk
rgb_data  output  24  last decoded pixel, {R[7:0],G[7:0],B[7:0]} (wire order is G,R,B, MSB first)
led_num  output  8  index of pixel on rgb_data within current frame, 0-based
pixel_valid  output  1  one-cycle strobe; rgb_data and led_num valid
frame_done  output  1  one-cycle strobe on latch gap after at least one bit received
error  output  1  one-cycle strobe on glitch, stuck-high or partial-pixel frame
overflow  output  1  sticky; set when more than 256 pixels arrive in one frame; cleared at frame_done

Behaviour:
- Reset (reset_n low at posedge clk): all outputs 0, all counters 0, state SYNC. Reset applies mid-frame; any partial pixel is discarded.
- Input conditioning: din passes through a 2-FF synchronizer (din_s). Edges are detected against the registered previous value of din_s.
- Counters: hi_cnt and low_cnt saturate and never wrap. hi_cnt counts din_s high cycles, counting the first high cycle as 1.
- SYNC: counts consecutive low cycles.
  - Any high cycle clears the count.
  - Reaching RESET_CYCLES -> IDLE.
  - No bits are accepted in SYNC; the state is entered after reset and after any error.
- IDLE: on a rising edge -> HIGH with hi_cnt=1.
- HIGH: hi_cnt increments each high cycle.
  - hi_cnt > MAX_HIGH -> error strobe, discard partial pixel, -> SYNC.
  - First low cycle with hi_cnt < MIN_HIGH -> error strobe, discard, -> SYNC.
  - Otherwise bit = (hi_cnt >= BIT_THRESH). Shift the bit into a 24-bit register MSB first, increment bit_cnt, go to LOW with low_cnt=1.
- LOW:
  - Rising edge -> HIGH.
  - low_cnt reaching RESET_CYCLES = end of frame:
    - frame_done strobe, but only if a bit was received in this frame.
    - If bit_cnt != 0, error strobe in the same cycle and the partial pixel is dropped.
    - led_num counter, bit_cnt and overflow clear; -> IDLE.
- Pixel completion: when bit_cnt reaches 24, in the next clk cycle:
  - pixel_valid=1, rgb_data={shift[15:8],shift[23:16],shift[7:0]}, led_num=pixel index.
  - bit_cnt returns to 0 and the index increments.
- Index saturation: at index 255 the index saturates; the 257th and later pixels set overflow and are still output with led_num=255.
- Latency: pixel_valid is asserted 4 clk cycles after the falling edge of the 24th bit's high pulse at the din pin (2 synchronizer cycles, 1 detect cycle, 1 output register cycle).
- Hold: rgb_data and led_num hold their value between strobes.
- Timing tolerance: bit low-time is not checked, except for latch detection.
- Exclusivity: pixel_valid and frame_done never assert in the same cycle.

Test Plan:
- Nominal pixel: reset, 800 low, one pixel with bits 0 coded 6H/14L and 1 coded 13H/7L, wire bytes G=00,R=7F,B=00, then 800 low -> single pixel_valid with rgb_data=24'h7F0000 and led_num=0, then one frame_done, error never set.
- Multi-pixel frame: 8 pixels alternating 24'h7F0000/24'h007F00, then gap -> 8 strobes with led_num 0..7 and matching data, one frame_done; next frame restarts at led_num=0.
- Threshold boundary: all-bits pixel with high=9 cycles -> rgb_data=24'h000000; high=10 cycles -> 24'hFFFFFF.
- Glitch and stuck line:
  - 2-cycle high pulse mid-pixel -> error strobe, no pixel_valid until 800 low cycles have elapsed, then the next pixel decodes correctly.
  - 40-cycle high -> error strobe.
- Partial frame: 12 bits then gap -> frame_done and error in the same cycle, no pixel_valid.
- Reset mid-pixel: reset_n low for 1 cycle after 10 bits -> outputs 0; bits before an 800-cycle gap are ignored.
- Overflow: 257 pixels in one frame -> overflow=1, led_num stays 255; overflow clears at frame_done.
